// File: rtl/budget_timer.sv
// Transaction budget watchdog: counts the outstanding cycle budget down in
// prescaled ticks and flags a sticky timeout (plus one-cycle irq) when it runs out.
module budget_timer #(
    parameter int CntWidth     = 16,
    parameter int PrescalerDiv = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                busy_i,
    input  logic [CntWidth-1:0] accum_budget_i,
    input  logic                txn_new_i,
    input  logic                txn_done_i,
    input  logic                clear_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic [1:0]          state_o,
    output logic                timeout_o,
    output logic                irq_o
);

    localparam int PscW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam logic [PscW-1:0] PscLast = PscW'(PrescalerDiv - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [PscW-1:0]     psc_q, psc_d;
    logic                timeout_q, timeout_d;
    logic                irq_q, irq_d;
    logic                tick;
    logic                reload;

    // With PrescalerDiv == 1 the prescaler is stuck at 0 == PscLast, so every cycle ticks.
    assign tick   = (psc_q == PscLast);
    assign reload = txn_new_i | txn_done_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psc_d     = psc_q;
        timeout_d = timeout_q;
        irq_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                psc_d     = '0;
                timeout_d = 1'b0;
                if (!clear_i && enable_i && busy_i) begin
                    state_d = COUNT;
                    cnt_d   = accum_budget_i;
                end
            end
            COUNT: begin
                if (clear_i || !enable_i || !busy_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    psc_d   = '0;
                end else if (reload) begin
                    // A reload beats a coincident tick, even the one that would time out.
                    cnt_d = accum_budget_i;
                    psc_d = '0;
                end else if (tick) begin
                    psc_d = '0;
                    if (cnt_q == '0) begin
                        state_d   = TIMEOUT;
                        timeout_d = 1'b1;
                        irq_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end else begin
                    psc_d = psc_q + PscW'(1);
                end
            end
            TIMEOUT: begin
                cnt_d     = '0;
                psc_d     = '0;
                timeout_d = 1'b1;
                if (clear_i) begin
                    state_d   = IDLE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                psc_d     = '0;
                timeout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            psc_q     <= '0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psc_q     <= psc_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign state_o   = state_q;
    assign timeout_o = timeout_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_budget_timer.sv
// Bench for budget_timer: directed scenarios plus random traffic, all checked
// against an elapsed-time model (remaining = budget - elapsed/div).
module tb_budget_timer;

    localparam int CW = 8;
    localparam int PD = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          busy_i = 1'b0;
    logic [CW-1:0] accum_budget_i = '0;
    logic          txn_new_i = 1'b0;
    logic          txn_done_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [CW-1:0] cnt_o;
    logic [1:0]    state_o;
    logic          timeout_o;
    logic          irq_o;

    budget_timer #(.CntWidth(CW), .PrescalerDiv(PD)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .busy_i        (busy_i),
        .accum_budget_i(accum_budget_i),
        .txn_new_i     (txn_new_i),
        .txn_done_i    (txn_done_i),
        .clear_i       (clear_i),
        .cnt_o         (cnt_o),
        .state_o       (state_o),
        .timeout_o     (timeout_o),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 idle / 1 counting / 2 timed out; budget b loaded e edges ago.
    int m_mode = 0;
    int m_b    = 0;
    int m_e    = 0;
    bit m_irq  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_b    = 0;
        m_e    = 0;
        m_irq  = 1'b0;
    endfunction

    function automatic void model_edge();
        if (rst_i) begin
            model_reset();
            return;
        end
        m_irq = 1'b0;
        case (m_mode)
            0: if (!clear_i && enable_i && busy_i) begin
                m_mode = 1;
                m_b    = int'(accum_budget_i);
                m_e    = 0;
            end
            1: if (clear_i || !enable_i || !busy_i) begin
                m_mode = 0;
            end else if (txn_new_i || txn_done_i) begin
                m_b = int'(accum_budget_i);
                m_e = 0;
            end else begin
                m_e++;
                if (m_e == PD * (m_b + 1)) begin
                    m_mode = 2;
                    m_irq  = 1'b1;
                end
            end
            default: if (clear_i) m_mode = 0;
        endcase
    endfunction

    task automatic check_outputs();
        int exp_cnt;
        exp_cnt = (m_mode == 1) ? (m_b - m_e / PD) : 0;
        chk("cnt", 32'(cnt_o), exp_cnt);
        chk("state", 32'(state_o), m_mode);
        chk("timeout", 32'(timeout_o), (m_mode == 2) ? 1 : 0);
        chk("irq", 32'(irq_o), 32'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_timeout(output int n);
        n = 0;
        while (!timeout_o && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic to_idle();
        enable_i   = 1'b0;
        busy_i     = 1'b0;
        clear_i    = 1'b1;
        txn_new_i  = 1'b0;
        txn_done_i = 1'b0;
        cycle();
        clear_i = 1'b0;
        cycle();
    endtask

    task automatic arm(input int b);
        accum_budget_i = CW'(b);
        enable_i       = 1'b1;
        busy_i         = 1'b1;
        cycle();
    endtask

    initial begin
        int n;
        // Reset state
        model_reset();
        cycle();
        chk("rst_cnt", 32'(cnt_o), 0);
        chk("rst_state", 32'(state_o), 0);
        rst_i = 1'b0;
        cycle();

        // Basic timeout B=3
        arm(3);
        chk("basic_load", 32'(cnt_o), 3);
        wait_timeout(n);
        chk("basic_latency", n, 8);
        chk("basic_irq", 32'(irq_o), 1);
        cycle();
        chk("basic_irq_width", 32'(irq_o), 0);
        chk("basic_sticky", 32'(timeout_o), 1);
        clear_i = 1'b1;
        enable_i = 1'b0;
        cycle();
        chk("clear_state", 32'(state_o), 0);
        chk("clear_timeout", 32'(timeout_o), 0);
        to_idle();

        // Zero budget
        arm(0);
        wait_timeout(n);
        chk("zero_latency", n, 2);
        cycle();
        chk("zero_irq_width", 32'(irq_o), 0);
        to_idle();

        // Reload via txn_done at edge 5
        arm(3);
        repeat (4) cycle();
        accum_budget_i = 8'd4;
        txn_done_i     = 1'b1;
        cycle();
        txn_done_i     = 1'b0;
        accum_budget_i = 8'd9;   // must be ignored until the next load
        chk("reload_cnt", 32'(cnt_o), 4);
        wait_timeout(n);
        chk("reload_latency", n, 10);
        to_idle();

        // Reload coincident with the cnt==0 tick
        arm(0);
        cycle();
        txn_new_i = 1'b1;
        cycle();
        txn_new_i = 1'b0;
        chk("reload_vs_tick_to", 32'(timeout_o), 0);
        chk("reload_vs_tick_st", 32'(state_o), 1);
        wait_timeout(n);
        chk("reload_vs_tick_lat", n, 2);
        to_idle();

        // Busy drop at edge 4
        arm(5);
        repeat (3) cycle();
        busy_i = 1'b0;
        cycle();
        chk("busy_state", 32'(state_o), 0);
        chk("busy_cnt", 32'(cnt_o), 0);
        repeat (12) cycle();
        chk("busy_timeout", 32'(timeout_o), 0);
        to_idle();

        // Clear on the would-be timeout edge
        arm(1);
        repeat (3) cycle();
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        enable_i = 1'b0;
        chk("clr_edge_state", 32'(state_o), 0);
        chk("clr_edge_irq", 32'(irq_o), 0);
        chk("clr_edge_to", 32'(timeout_o), 0);
        to_idle();

        // Asynchronous reset mid-count
        arm(3);
        repeat (2) cycle();
        chk("pre_rst_cnt", 32'(cnt_o), 2);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        chk("rst_async_cnt", 32'(cnt_o), 0);
        check_outputs();
        accum_budget_i = 8'd6;
        cycle();
        rst_i = 1'b0;
        cycle();
        chk("post_rst_load", 32'(cnt_o), 6);
        chk("post_rst_state", 32'(state_o), 1);
        to_idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable_i       = ($urandom_range(0, 99) < 95);
            busy_i         = ($urandom_range(0, 99) < 92);
            clear_i        = ($urandom_range(0, 99) < 3);
            txn_new_i      = ($urandom_range(0, 99) < 5);
            txn_done_i     = ($urandom_range(0, 99) < 5);
            accum_budget_i = CW'($urandom_range(0, 12));
            rst_i          = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/budget_timer.md
BUDGET_TIMER -- requirements
Module: budget_timer

Interface
REQ-001 The block SHALL have parameter CntWidth, default 16, giving the width of the budget input and the countdown counter.
REQ-002 The block SHALL have parameter PrescalerDiv, default 2, giving the clock cycles per countdown tick; legal values are powers of two >= 1.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port enable_i, input, 1 bit, which arms the timer.
REQ-006 The block SHALL have port busy_i, input, 1 bit, high while at least one transaction is outstanding.
REQ-007 The block SHALL have port accum_budget_i, input, CntWidth bits, the accumulated cycle budget (in ticks) of all outstanding transactions, from the budget accumulator stage.
REQ-008 The block SHALL have port txn_new_i, input, 1 bit, a one-cycle pulse when a transaction is admitted.
REQ-009 The block SHALL have port txn_done_i, input, 1 bit, a one-cycle pulse when a transaction completes.
REQ-010 The block SHALL have port clear_i, input, 1 bit, which acknowledges or clears a timeout.
REQ-011 The block SHALL have port cnt_o, output, CntWidth bits, the current remaining budget.
REQ-012 The block SHALL have port state_o, output, 2 bits, with encoding IDLE=0, COUNT=1, TIMEOUT=2.
REQ-013 The block SHALL have port timeout_o, output, 1 bit, a sticky timeout flag.
REQ-014 The block SHALL have port irq_o, output, 1 bit, a one-cycle pulse on entry to TIMEOUT.

Function
REQ-015 The block SHALL implement an FSM with the states IDLE, COUNT and TIMEOUT; all outputs SHALL be registered.
REQ-016 The prescaler counter SHALL have width max(1, $clog2(PrescalerDiv)).
- A tick occurs in COUNT when the prescaler equals PrescalerDiv-1; the prescaler then wraps to 0.
- With PrescalerDiv=1, a tick SHALL occur every COUNT cycle.
REQ-017 IDLE -> COUNT SHALL occur when enable_i && busy_i && !clear_i.
- On this transition, cnt loads accum_budget_i and the prescaler is set to 0.
REQ-018 Event priority in COUNT SHALL be, highest first:
- clear_i -> IDLE, cnt=0;
- !enable_i or !busy_i -> IDLE, cnt=0, no irq;
- txn_new_i or txn_done_i -> reload cnt=accum_budget_i, prescaler=0;
- tick with cnt==0 -> TIMEOUT;
- tick with cnt>0 -> cnt-1.
REQ-019 A reload SHALL win over a simultaneous tick, including the cnt==0 case, so no timeout occurs that cycle.
REQ-020 cnt SHALL never wrap below 0; the block SHALL use no addition, only load and decrement.
REQ-021 On entry to TIMEOUT, timeout_o SHALL go to 1 and irq_o SHALL be 1 for exactly that one cycle.
REQ-022 In TIMEOUT, cnt SHALL hold 0 and the prescaler SHALL be idle.
- txn_new_i, txn_done_i, busy_i and enable_i SHALL be ignored.
- Only clear_i causes the transition to IDLE, and timeout_o returns to 0 in the same edge.
REQ-023 clear_i in IDLE SHALL keep the block in IDLE, with priority over arming.
REQ-024 Latency with a constant budget B and no reloads: timeout_o SHALL rise exactly PrescalerDiv*(B+1) clock edges after the IDLE->COUNT edge.
REQ-025 accum_budget_i SHALL be sampled only on load or reload edges; changes between those edges SHALL have no effect.

Reset
REQ-026 While rst_i=1, asynchronously: state=IDLE, cnt_o=0, prescaler=0, timeout_o=0, irq_o=0.
REQ-027 Reset asserted mid-COUNT or in TIMEOUT SHALL discard all progress and SHALL produce no irq pulse; operation resumes from IDLE on the first edge after release.

Verification
REQ-028 With CntWidth=8 and PrescalerDiv=2, the bench SHALL cover at least these directed scenarios:
- Basic timeout: B=3, enable=busy=1 held -> cnt_o goes 3,2,1,0 every 2 cycles; timeout_o and a 1-cycle irq_o rise 8 edges after load.
- Zero budget: B=0 -> timeout after 2 edges; irq_o is exactly 1 cycle wide.
- Reload: B=3, txn_done_i pulses 5 edges after load with accum_budget_i=4 -> cnt_o=4 and timeout_o rises 10 edges after the pulse; a reload coincident with the cnt==0 tick produces no timeout.
- Busy drop: B=5, busy_i falls at edge 4 -> IDLE, cnt_o=0, timeout_o and irq_o stay 0.
- Clear: in TIMEOUT, clear_i=1 -> IDLE and timeout_o=0 next edge; clear_i on the would-be timeout edge -> IDLE, no irq.
- Reset: rst_i asserted asynchronously between edges in COUNT (cnt_o=2) -> all outputs 0 immediately; after release with busy=1, reload from accum_budget_i.
